// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the two data-RAM requesters (core port C, debug port D).
// The requesters use the master modport, and the arbiter uses the slave modport.
interface dmem_arbiter_if #(
   parameter int ADDR_SIZE = 10,
   parameter int DATA_SIZE = 32
);
   logic                 c_req;
   logic                 c_we;
   logic [ADDR_SIZE-1:0] c_addr;
   logic [DATA_SIZE-1:0] c_wdata;
   logic                 c_gnt;
   logic                 c_rvalid;
   logic [DATA_SIZE-1:0] c_rdata;

   logic                 d_req;
   logic                 d_we;
   logic                 d_lock;
   logic [ADDR_SIZE-1:0] d_addr;
   logic [DATA_SIZE-1:0] d_wdata;
   logic                 d_gnt;
   logic                 d_rvalid;
   logic [DATA_SIZE-1:0] d_rdata;

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output d_req, d_we, d_lock, d_addr, d_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      input  d_gnt, d_rvalid, d_rdata
   );

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  d_req, d_we, d_lock, d_addr, d_wdata,
      output c_gnt, c_rvalid, c_rdata,
      output d_gnt, d_rvalid, d_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data RAM between the core (C) and debug (D) ports. D gets bounded-wait priority
// and a lock mode for bursts. Read returns are tagged with the requester through a latency-matched pipeline.
module dmem_arbiter #(
   parameter int ADDR_SIZE = 10,
   parameter int DATA_SIZE = 32,
   parameter int RD_LAT    = 1,
   parameter int MAX_WAIT  = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   dmem_arbiter_if.slave        bus,
   output logic [ADDR_SIZE-1:0] daddr,
   output logic [DATA_SIZE-1:0] ddata_w,
   output logic                 MemWrite,
   output logic                 MemRead,
   input  logic [DATA_SIZE-1:0] ddata_r
);

   localparam logic [0:0] ARB    = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   logic [0:0]           state, state_nxt;
   logic [7:0]           wait_cnt, wait_nxt;
   logic                 d_force;
   logic                 c_gnt, d_gnt, any_gnt;
   logic                 gnt_we;
   logic [ADDR_SIZE-1:0] gnt_addr, addr_q;
   logic [DATA_SIZE-1:0] gnt_wdata, wdata_q;
   logic                 rd_issue;
   logic [RD_LAT-1:0]    tag_v, tag_d;
   logic [RD_LAT:0]      tag_v_shift, tag_d_shift;
   logic                 ret_v, ret_d;

   // Grant decision. Nothing is granted while reset is asserted.
   always_comb begin
      d_force   = (wait_cnt == WAIT_LIMIT);
      c_gnt     = 1'b0;
      d_gnt     = 1'b0;
      state_nxt = state;
      if (!RESET) begin
         case (state)
            ARB: begin
               d_gnt = bus.d_req & (~bus.c_req | d_force);
               c_gnt = bus.c_req & ~d_gnt;
               if (d_gnt && bus.d_lock) state_nxt = LOCKED;
            end
            LOCKED: begin
               d_gnt = bus.d_req;
               if (!bus.d_lock) state_nxt = ARB;
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   always_comb begin
      wait_nxt = '0;
      if (bus.d_req && !d_gnt) wait_nxt = d_force ? wait_cnt : wait_cnt + 8'd1;
   end

   always_comb begin
      any_gnt   = c_gnt | d_gnt;
      gnt_we    = d_gnt ? bus.d_we    : bus.c_we;
      gnt_addr  = d_gnt ? bus.d_addr  : bus.c_addr;
      gnt_wdata = d_gnt ? bus.d_wdata : bus.c_wdata;
      MemWrite  = any_gnt & gnt_we;
      MemRead   = any_gnt & ~gnt_we;
      rd_issue  = MemRead;
      // When idle, the RAM address and write-data buses keep the last granted values.
      daddr     = any_gnt ? gnt_addr  : addr_q;
      ddata_w   = any_gnt ? gnt_wdata : wdata_q;
   end

   // Stage 0 of the tag pipeline takes the current read issue. The oldest stage marks the return cycle.
   always_comb begin
      tag_v_shift = {tag_v, rd_issue};
      tag_d_shift = {tag_d, d_gnt};
      ret_v       = tag_v[RD_LAT-1];
      ret_d       = tag_d[RD_LAT-1];
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= ARB;
         wait_cnt <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         tag_v    <= '0;
         tag_d    <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         addr_q   <= daddr;
         wdata_q  <= ddata_w;
         tag_v    <= tag_v_shift[RD_LAT-1:0];
         tag_d    <= tag_d_shift[RD_LAT-1:0];
      end
   end

   always_comb begin
      bus.c_gnt    = c_gnt;
      bus.d_gnt    = d_gnt;
      bus.c_rvalid = ret_v & ~ret_d;
      bus.d_rvalid = ret_v & ret_d;
      bus.c_rdata  = (ret_v & ~ret_d) ? ddata_r : '0;
      bus.d_rdata  = (ret_v & ret_d)  ? ddata_r : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Two instances receive the same stimulus (RD_LAT=1 and RD_LAT=2), and each instance has its own RAM read pipeline.
module tb_dmem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MW = 8;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic          RESET;
   logic          c_req, c_we, d_req, d_we, d_lock;
   logic [AW-1:0] c_addr, d_addr;
   logic [DW-1:0] c_wdata, d_wdata;

   logic [AW-1:0] daddr1, daddr2;
   logic [DW-1:0] ddata_w1, ddata_w2, ddata_r1, ddata_r2;
   logic          MemWrite1, MemWrite2, MemRead1, MemRead2;

   int checks = 0;
   int errors = 0;

   dmem_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus1 ();
   dmem_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus2 ();

   assign bus1.c_req = c_req;    assign bus2.c_req = c_req;
   assign bus1.c_we = c_we;      assign bus2.c_we = c_we;
   assign bus1.c_addr = c_addr;  assign bus2.c_addr = c_addr;
   assign bus1.c_wdata = c_wdata; assign bus2.c_wdata = c_wdata;
   assign bus1.d_req = d_req;    assign bus2.d_req = d_req;
   assign bus1.d_we = d_we;      assign bus2.d_we = d_we;
   assign bus1.d_lock = d_lock;  assign bus2.d_lock = d_lock;
   assign bus1.d_addr = d_addr;  assign bus2.d_addr = d_addr;
   assign bus1.d_wdata = d_wdata; assign bus2.d_wdata = d_wdata;

   dmem_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LAT(1), .MAX_WAIT(MW)) u_dut (
      .CLK(CLK), .RESET(RESET), .bus(bus1),
      .daddr(daddr1), .ddata_w(ddata_w1), .MemWrite(MemWrite1), .MemRead(MemRead1),
      .ddata_r(ddata_r1)
   );

   dmem_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LAT(2), .MAX_WAIT(MW)) u_dut2 (
      .CLK(CLK), .RESET(RESET), .bus(bus2),
      .daddr(daddr2), .ddata_w(ddata_w2), .MemWrite(MemWrite2), .MemRead(MemRead2),
      .ddata_r(ddata_r2)
   );

   // RAM model: word i starts at 0x100+i, except word 3, which starts at 0x21. Writes come from the first instance only.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] p1, p2a, p2b;
   logic          init_done = 1'b0;

   always @(posedge CLK) begin
      if (!init_done) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(32'h100 + i);
         mem[3]    <= 32'h21;
         init_done <= 1'b1;
      end else if (MemWrite1) begin
         mem[daddr1] <= ddata_w1;
      end
      if (MemRead1) p1  <= mem[daddr1];
      if (MemRead2) p2a <= mem[daddr2];
      p2b <= p2a;
   end

   assign ddata_r1 = p1;
   assign ddata_r2 = p2b;

   typedef struct {
      logic          c_req, c_we;
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wdata;
      logic          d_req, d_we, d_lock;
      logic [AW-1:0] d_addr;
      logic [DW-1:0] d_wdata;
      logic          e_cg, e_dg, e_rd, e_wr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic          e_crv, e_drv;
      logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t vecs [10];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic set_c(input logic rq, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      c_req = rq; c_we = we; c_addr = a; c_wdata = wd;
   endtask

   task automatic set_d(input logic rq, input logic we, input logic lk, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
      d_req = rq; d_we = we; d_lock = lk; d_addr = a; d_wdata = wd;
   endtask

   task automatic rst_checks(input string tag);
      chk1({tag, " c_gnt"}, bus1.c_gnt, 1'b0);
      chk1({tag, " d_gnt"}, bus1.d_gnt, 1'b0);
      chk1({tag, " MemRead"}, MemRead1, 1'b0);
      chk1({tag, " MemWrite"}, MemWrite1, 1'b0);
      chka({tag, " daddr"}, daddr1, '0);
      chkd({tag, " ddata_w"}, ddata_w1, '0);
      chk1({tag, " c_rvalid"}, bus1.c_rvalid, 1'b0);
      chkd({tag, " c_rdata"}, bus1.c_rdata, '0);
      chk1({tag, " d_rvalid"}, bus1.d_rvalid, 1'b0);
      chkd({tag, " d_rdata"}, bus1.d_rdata, '0);
      chk1({tag, " lat2 c_rvalid"}, bus2.c_rvalid, 1'b0);
      chk1({tag, " lat2 MemWrite"}, MemWrite2, 1'b0);
      chkd({tag, " lat2 ddata_w"}, ddata_w2, '0);
   endtask

   initial begin
      //            c: req we addr wdata  d: req we lk addr wdata    exp: cg dg rd wr addr wd  crv drv rdata
      vecs[0] = '{0, 0, 0, 0,            0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0,        0, 0, 0};
      vecs[1] = '{1, 0, 3, 0,            0, 0, 0, 0, 0,              1, 0, 1, 0, 3, 0,        0, 0, 0};
      vecs[2] = '{0, 0, 0, 0,            0, 0, 0, 0, 0,              0, 0, 0, 0, 3, 0,        1, 0, 32'h21};
      vecs[3] = '{0, 0, 0, 0,            1, 0, 0, 2, 0,              0, 1, 1, 0, 2, 0,        0, 0, 0};
      vecs[4] = '{1, 1, 9, 32'h55,       0, 0, 0, 0, 0,              1, 0, 0, 1, 9, 32'h55,   0, 1, 32'h102};
      vecs[5] = '{0, 0, 0, 0,            0, 0, 0, 0, 0,              0, 0, 0, 0, 9, 32'h55,   0, 0, 0};
      vecs[6] = '{1, 0, 1, 0,            1, 1, 0, 4, 32'hAA,         1, 0, 1, 0, 1, 0,        0, 0, 0};
      vecs[7] = '{0, 0, 0, 0,            1, 1, 0, 4, 32'hAA,         0, 1, 0, 1, 4, 32'hAA,   1, 0, 32'h101};
      vecs[8] = '{0, 0, 0, 0,            1, 0, 0, 4, 0,              0, 1, 1, 0, 4, 0,        0, 0, 0};
      vecs[9] = '{0, 0, 0, 0,            0, 0, 0, 0, 0,              0, 0, 0, 0, 4, 0,        0, 1, 32'hAA};

      RESET = 1'b1;
      set_c(0, 0, 0, 0);
      set_d(0, 0, 0, 0, 0);
      settle();
      rst_checks("por");
      RESET = 1'b0;

      for (int i = 0; i < 10; i++) begin
         tick();
         set_c(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata);
         set_d(vecs[i].d_req, vecs[i].d_we, vecs[i].d_lock, vecs[i].d_addr, vecs[i].d_wdata);
         settle();
         chk1($sformatf("v%0d c_gnt", i), bus1.c_gnt, vecs[i].e_cg);
         chk1($sformatf("v%0d d_gnt", i), bus1.d_gnt, vecs[i].e_dg);
         chk1($sformatf("v%0d MemRead", i), MemRead1, vecs[i].e_rd);
         chk1($sformatf("v%0d MemWrite", i), MemWrite1, vecs[i].e_wr);
         chka($sformatf("v%0d daddr", i), daddr1, vecs[i].e_addr);
         chkd($sformatf("v%0d ddata_w", i), ddata_w1, vecs[i].e_wd);
         chk1($sformatf("v%0d c_rvalid", i), bus1.c_rvalid, vecs[i].e_crv);
         chk1($sformatf("v%0d d_rvalid", i), bus1.d_rvalid, vecs[i].e_drv);
         chkd($sformatf("v%0d c_rdata", i), bus1.c_rdata, vecs[i].e_crv ? vecs[i].e_rdata : '0);
         chkd($sformatf("v%0d d_rdata", i), bus1.d_rdata, vecs[i].e_drv ? vecs[i].e_rdata : '0);
      end

      // Interleaved reads on the RD_LAT=2 instance: C@1, D@2, C@3
      tick(); set_c(1, 0, 1, 0); set_d(0, 0, 0, 0, 0); settle();
      chk1("il c gnt", bus2.c_gnt, 1'b1);
      tick(); set_c(0, 0, 0, 0); set_d(1, 0, 0, 2, 0); settle();
      chk1("il d gnt", bus2.d_gnt, 1'b1);
      chk1("il early c_rvalid", bus2.c_rvalid, 1'b0);
      tick(); set_c(1, 0, 3, 0); set_d(0, 0, 0, 0, 0); settle();
      chk1("il ret1 c_rvalid", bus2.c_rvalid, 1'b1);
      chk1("il ret1 d_rvalid", bus2.d_rvalid, 1'b0);
      chkd("il ret1 c_rdata", bus2.c_rdata, 32'h101);
      tick(); set_c(0, 0, 0, 0); settle();
      chk1("il ret2 d_rvalid", bus2.d_rvalid, 1'b1);
      chk1("il ret2 c_rvalid", bus2.c_rvalid, 1'b0);
      chkd("il ret2 d_rdata", bus2.d_rdata, 32'h102);
      tick(); settle();
      chk1("il ret3 c_rvalid", bus2.c_rvalid, 1'b1);
      chkd("il ret3 c_rdata", bus2.c_rdata, 32'h21);
      tick(); settle();
      chk1("il tail c_rvalid", bus2.c_rvalid, 1'b0);
      chk1("il tail d_rvalid", bus2.d_rvalid, 1'b0);

      // Starvation: D is forced through on the 9th cycle of waiting
      for (int k = 1; k <= 9; k++) begin
         tick(); set_c(1, 0, 0, 0); set_d(1, 1, 0, 7, 32'hDEADBEEF); settle();
         if (k < 9) begin
            chk1($sformatf("starve k%0d c_gnt", k), bus1.c_gnt, 1'b1);
            chk1($sformatf("starve k%0d d_gnt", k), bus1.d_gnt, 1'b0);
         end else begin
            chk1("starve force d_gnt", bus1.d_gnt, 1'b1);
            chk1("starve force c_gnt", bus1.c_gnt, 1'b0);
            chk1("starve force MemWrite", MemWrite1, 1'b1);
            chka("starve force daddr", daddr1, 7);
            chkd("starve force ddata_w", ddata_w1, 32'hDEADBEEF);
         end
      end
      tick(); set_d(0, 0, 0, 0, 0); settle();
      chk1("starve resume c_gnt", bus1.c_gnt, 1'b1);
      chk1("starve no c_rvalid", bus1.c_rvalid, 1'b0);
      tick(); set_c(0, 0, 0, 0); settle();

      // Lock burst: enter through forced priority, then write addresses 0..3 while C keeps requesting
      for (int k = 1; k <= 8; k++) begin
         tick(); set_c(1, 0, 0, 0); set_d(1, 1, 1, 0, 32'h50); settle();
         chk1($sformatf("lock wait k%0d c_gnt", k), bus1.c_gnt, 1'b1);
      end
      tick(); settle();
      chk1("lock w0 d_gnt", bus1.d_gnt, 1'b1);
      chk1("lock w0 c_gnt", bus1.c_gnt, 1'b0);
      chka("lock w0 daddr", daddr1, 0);
      for (int k = 1; k <= 3; k++) begin
         logic lk;
         lk = (k != 3);
         tick(); set_d(1, 1, lk, AW'(k), DW'(32'h50 + k)); settle();
         chk1($sformatf("lock w%0d d_gnt", k), bus1.d_gnt, 1'b1);
         chk1($sformatf("lock w%0d c_gnt", k), bus1.c_gnt, 1'b0);
         chk1($sformatf("lock w%0d MemWrite", k), MemWrite1, 1'b1);
         chka($sformatf("lock w%0d daddr", k), daddr1, AW'(k));
      end
      tick(); set_d(0, 0, 0, 0, 0); settle();
      chk1("lock done c_gnt", bus1.c_gnt, 1'b1);

      // Lock with a gap: D idle while locked keeps C out until the lock drops
      tick(); set_c(0, 0, 0, 0); set_d(1, 0, 1, 2, 0); settle();
      chk1("gap enter d_gnt", bus1.d_gnt, 1'b1);
      chk1("gap enter MemRead", MemRead1, 1'b1);
      tick(); set_c(1, 0, 5, 0); set_d(0, 0, 1, 0, 0); settle();
      chk1("gap idle c_gnt", bus1.c_gnt, 1'b0);
      chk1("gap idle d_gnt", bus1.d_gnt, 1'b0);
      chk1("gap idle MemRead", MemRead1, 1'b0);
      chk1("gap idle MemWrite", MemWrite1, 1'b0);
      chka("gap idle daddr", daddr1, 2);
      chk1("gap d_rvalid", bus1.d_rvalid, 1'b1);
      chkd("gap d_rdata", bus1.d_rdata, 32'h52);
      tick(); set_d(0, 0, 0, 0, 0); settle();
      chk1("gap release c_gnt", bus1.c_gnt, 1'b0);
      tick(); settle();
      chk1("gap after c_gnt", bus1.c_gnt, 1'b1);
      chk1("gap after MemRead", MemRead1, 1'b1);
      chka("gap after daddr", daddr1, 5);

      // Reset while the C read of address 5 is still pending
      tick();
      RESET = 1'b1;
      settle();
      rst_checks("midrst");
      RESET = 1'b0;
      set_c(0, 0, 0, 0);
      tick(); set_c(1, 0, 6, 0); set_d(1, 0, 0, 7, 0); settle();
      chk1("post rst c_rvalid", bus1.c_rvalid, 1'b0);
      chk1("post rst lat2 c_rvalid", bus2.c_rvalid, 1'b0);
      chk1("post rst c_gnt", bus1.c_gnt, 1'b1);
      chk1("post rst d_gnt", bus1.d_gnt, 1'b0);
      tick(); set_c(0, 0, 0, 0); set_d(0, 0, 0, 0, 0); settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
